pll_lock_sequencer: RTL and testbench

Parametrised PLL bring-up and reset-release controller, clocked from the PLL reference clock. It enables the PLL after a power-up delay, then waits for LOCK with a timeout. It requires LOCK to stay stable for a qualification window, then releases per-output-domain resets in a staggered order. On lock loss or timeout it retries a bounded number of times and then latches a fault. It sits between the input-buffered reference clock/reset and the PLL primitive's PLL_EN/LOCK pins, replacing ad-hoc tie-offs such as PLL_EN=1.

---
 rtl/pll_lock_seq_pkg.sv | 23 ++
 rtl/lock_sync.sv | 24 ++
 rtl/pll_lock_sequencer.sv | 165 ++++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pll_lock_seq_pkg.sv
// Shared types and sizing helpers for the PLL lock sequencer.
package pll_lock_seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4,
    FAULT     = 3'd5
  } state_e;

  // Counter width large enough for the longest interval any state has to time.
  function automatic int cnt_width(input int startup, input int timeout, input int rel_span);
    int m;
    m = startup;
    if (timeout > m) m = timeout;
    if (rel_span > m) m = rel_span;
    if (m < 1) m = 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/lock_sync.sv
// Two-flop synchroniser for a single asynchronous level; clears to 0 on reset.
module lock_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL bring-up and staggered reset-release controller.
// Lock-loss monitoring in RELEASE/RUN is enabled by defining PLL_LOCK_SEQ_LOSS_MON_EN.
module pll_lock_sequencer
  import pll_lock_seq_pkg::*;
#(
  parameter int NUM_CH         = 5,
  parameter int STARTUP_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 1024,
  parameter int LOCK_STABLE    = 64,
  parameter int STAGGER        = 4,
  parameter int MAX_RETRIES    = 3,
  localparam int RET_W         = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1)
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              lock,
  input  logic              restart,
  output logic              pll_en,
  output logic [NUM_CH-1:0] chan_rst,
  output logic              ready,
  output logic              fault,
  output logic [RET_W-1:0]  retries
);

  localparam int CNT_W = cnt_width(STARTUP_CYCLES, LOCK_TIMEOUT, STAGGER * NUM_CH);
  localparam logic [CNT_W-1:0] STARTUP_LAST = CNT_W'(STARTUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] REL_LAST     = CNT_W'(STAGGER * (NUM_CH - 1));
  localparam logic [RET_W-1:0] RET_MAX      = RET_W'(MAX_RETRIES);

  logic lock_s;

  lock_sync u_lock_sync (
    .clk (clk_in),
    .rst (reset),
    .d   (lock),
    .q   (lock_s)
  );

  state_e             state_q,    state_d;
  logic [CNT_W-1:0]   phase_q,    phase_d;
  logic [CNT_W-1:0]   tmo_q,      tmo_d;
  logic [RET_W-1:0]   retries_q,  retries_d;
  logic               pll_en_q,   pll_en_d;
  logic [NUM_CH-1:0]  chan_rst_q, chan_rst_d;
  logic               ready_q,    ready_d;
  logic               fault_q,    fault_d;
  logic               retry_evt;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    tmo_d     = tmo_q;
    retries_d = retries_q;
    retry_evt = 1'b0;

    case (state_q)
      IDLE: begin
        if (phase_q == STARTUP_LAST) begin
          state_d = WAIT_LOCK;
          phase_d = '0;
          tmo_d   = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      WAIT_LOCK: begin
        tmo_d = tmo_q + 1'b1;
        if (tmo_q == TMO_LAST) retry_evt = 1'b1;
        else if (lock_s) begin
          state_d = STABLE;
          phase_d = '0;
        end
      end
      // tmo keeps running across STABLE->WAIT_LOCK so a flapping lock still times out
      STABLE: begin
        tmo_d = tmo_q + 1'b1;
        if (tmo_q == TMO_LAST) retry_evt = 1'b1;
        else if (!lock_s) state_d = WAIT_LOCK;
        else if (phase_q == STABLE_LAST) begin
          state_d = RELEASE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      RELEASE: begin
`ifdef PLL_LOCK_SEQ_LOSS_MON_EN
        if (!lock_s) retry_evt = 1'b1;
        else
`endif
        if (phase_q == REL_LAST) state_d = RUN;
        else phase_d = phase_q + 1'b1;
      end
      RUN: begin
`ifdef PLL_LOCK_SEQ_LOSS_MON_EN
        if (!lock_s) retry_evt = 1'b1;
`endif
      end
      FAULT: ;
      default: state_d = IDLE;
    endcase

    if (retry_evt) begin
      phase_d = '0;
      if (retries_q < RET_MAX) begin
        retries_d = retries_q + 1'b1;
        state_d   = IDLE;
      end else begin
        state_d   = FAULT;
      end
    end

    if (restart) begin
      state_d   = IDLE;
      phase_d   = '0;
      tmo_d     = '0;
      retries_d = '0;
    end

    // Outputs are decoded from the next state so they register alongside it.
    pll_en_d = (state_d == WAIT_LOCK) || (state_d == STABLE) ||
               (state_d == RELEASE)   || (state_d == RUN);
    ready_d  = (state_d == RUN);
    fault_d  = (state_d == FAULT);
    chan_rst_d = '1;
    if (state_d == RUN) begin
      chan_rst_d = '0;
    end else if (state_d == RELEASE) begin
      for (int i = 0; i < NUM_CH; i++) begin
        chan_rst_d[i] = (phase_d < CNT_W'(STAGGER * i));
      end
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      tmo_q      <= '0;
      retries_q  <= '0;
      pll_en_q   <= 1'b0;
      chan_rst_q <= '1;
      ready_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      tmo_q      <= tmo_d;
      retries_q  <= retries_d;
      pll_en_q   <= pll_en_d;
      chan_rst_q <= chan_rst_d;
      ready_q    <= ready_d;
      fault_q    <= fault_d;
    end
  end

  assign pll_en   = pll_en_q;
  assign chan_rst = chan_rst_q;
  assign ready    = ready_q;
  assign fault    = fault_q;
  assign retries  = retries_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: cycle-stamped expectations, negedge monitor.
module tb_pll_lock_sequencer;

  logic       clk_in  = 1'b0;
  logic       reset   = 1'b1;
  logic       lock    = 1'b0;
  logic       restart = 1'b0;
  logic       pll_en;
  logic [4:0] chan_rst;
  logic       ready;
  logic       fault;
  logic [1:0] retries;

  pll_lock_sequencer #(
    .NUM_CH(5), .STARTUP_CYCLES(16), .LOCK_TIMEOUT(1024),
    .LOCK_STABLE(64), .STAGGER(4), .MAX_RETRIES(3)
  ) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .lock     (lock),
    .restart  (restart),
    .pll_en   (pll_en),
    .chan_rst (chan_rst),
    .ready    (ready),
    .fault    (fault),
    .retries  (retries)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    int         at;
    string      name;
    logic       pll_en;
    logic [4:0] chan_rst;
    logic       ready;
    logic       fault;
    logic [1:0] retries;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   total = 0;
  int   bad   = 0;
  int   base;

  task automatic expect_at(input int at, input string nm, input logic en,
                           input logic [4:0] cr, input logic rdy,
                           input logic flt, input logic [1:0] rt);
    exp_t e;
    e.at = at; e.name = nm; e.pll_en = en; e.chan_rst = cr;
    e.ready = rdy; e.fault = flt; e.retries = rt;
    sb.push_back(e);
  endtask

  always @(negedge clk_in) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      cur = sb.pop_front();
      total++;
      if (cur.at < cyc) begin
        bad++;
        $display("FAIL %s: due at cycle %0d but not sampled until %0d", cur.name, cur.at, cyc);
      end else if ({pll_en, chan_rst, ready, fault, retries} !==
                   {cur.pll_en, cur.chan_rst, cur.ready, cur.fault, cur.retries}) begin
        bad++;
        $display("FAIL %s @%0d: got pll_en=%b chan_rst=%h ready=%b fault=%b retries=%0d, want pll_en=%b chan_rst=%h ready=%b fault=%b retries=%0d",
                 cur.name, cyc, pll_en, chan_rst, ready, fault, retries,
                 cur.pll_en, cur.chan_rst, cur.ready, cur.fault, cur.retries);
      end
    end
  end

  task automatic at_cyc(input int c);
    while (cyc < c) @(negedge clk_in);
  endtask

  task automatic do_reset(input logic lk);
    @(negedge clk_in);
    reset = 1'b1; lock = lk; restart = 1'b0;
    repeat (2) @(negedge clk_in);
    expect_at(cyc + 1, "reset_state", 1'b0, 5'h1F, 1'b0, 1'b0, 2'd0);
    @(negedge clk_in);
    reset = 1'b0;
    base = cyc;
  endtask

  initial begin
    #(10 * 120000);
    $display("FAIL watchdog: simulation exceeded time limit, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int c;
    int r;

    // Nominal bring-up with lock high from the start.
    do_reset(1'b1);
    expect_at(base + 15, "startup_hold", 1'b0, 5'h1F, 1'b0, 1'b0, 2'd0);
    expect_at(base + 16, "pll_en_rise",  1'b1, 5'h1F, 1'b0, 1'b0, 2'd0);
    expect_at(base + 80, "stable_end",   1'b1, 5'h1F, 1'b0, 1'b0, 2'd0);
    expect_at(base + 81, "rel_ch0",      1'b1, 5'h1E, 1'b0, 1'b0, 2'd0);
    expect_at(base + 85, "rel_ch1",      1'b1, 5'h1C, 1'b0, 1'b0, 2'd0);
    expect_at(base + 97, "rel_ch4",      1'b1, 5'h00, 1'b0, 1'b0, 2'd0);
    expect_at(base + 98, "run_ready",    1'b1, 5'h00, 1'b1, 1'b0, 2'd0);
    at_cyc(base + 110);

    // Lock drops for 10 cycles while in RUN.
    c = cyc;
    lock = 1'b0;
    expect_at(c + 2, "loss_pre", 1'b1, 5'h00, 1'b1, 1'b0, 2'd0);
`ifdef PLL_LOCK_SEQ_LOSS_MON_EN
    expect_at(c + 3,   "loss_rst",   1'b0, 5'h1F, 1'b0, 1'b0, 2'd1);
    expect_at(c + 18,  "reseq_idle", 1'b0, 5'h1F, 1'b0, 1'b0, 2'd1);
    expect_at(c + 19,  "reseq_en",   1'b1, 5'h1F, 1'b0, 1'b0, 2'd1);
    expect_at(c + 100, "reseq_rel",  1'b1, 5'h00, 1'b0, 1'b0, 2'd1);
    expect_at(c + 101, "reseq_run",  1'b1, 5'h00, 1'b1, 1'b0, 2'd1);
`else
    expect_at(c + 3,  "loss_ignored", 1'b1, 5'h00, 1'b1, 1'b0, 2'd0);
    expect_at(c + 30, "run_held",     1'b1, 5'h00, 1'b1, 1'b0, 2'd0);
`endif
    at_cyc(c + 10);
    lock = 1'b1;
    at_cyc(c + 110);

    // Asynchronous reset in the middle of RELEASE.
    do_reset(1'b1);
    expect_at(base + 86, "mid_release", 1'b1, 5'h1C, 1'b0, 1'b0, 2'd0);
    at_cyc(base + 86);
    @(posedge clk_in);
    #1 reset = 1'b1;
    expect_at(cyc, "async_reset", 1'b0, 5'h1F, 1'b0, 1'b0, 2'd0);
    repeat (2) @(negedge clk_in);
    reset = 1'b0;
    base = cyc;
    expect_at(base + 15, "rst_restart_hold", 1'b0, 5'h1F, 1'b0, 1'b0, 2'd0);
    expect_at(base + 16, "rst_restart_en",   1'b1, 5'h1F, 1'b0, 1'b0, 2'd0);
    expect_at(base + 98, "rst_restart_run",  1'b1, 5'h00, 1'b1, 1'b0, 2'd0);
    at_cyc(base + 100);

    // Lock toggling every 40 cycles never qualifies; timeout still fires.
    do_reset(1'b1);
    expect_at(base + 1039, "flap_pre", 1'b1, 5'h1F, 1'b0, 1'b0, 2'd0);
    expect_at(base + 1040, "flap_tmo", 1'b0, 5'h1F, 1'b0, 1'b0, 2'd1);
    for (int k = 0; k < 27; k++) begin
      at_cyc(base + 40 * (k + 1));
      lock = ~lock;
    end

    // Lock never rises: three retries, then fault, then restart.
    do_reset(1'b0);
    expect_at(base + 16,   "nolock_en",    1'b1, 5'h1F, 1'b0, 1'b0, 2'd0);
    expect_at(base + 1039, "tmo1_pre",     1'b1, 5'h1F, 1'b0, 1'b0, 2'd0);
    expect_at(base + 1040, "tmo1",         1'b0, 5'h1F, 1'b0, 1'b0, 2'd1);
    expect_at(base + 2080, "tmo2",         1'b0, 5'h1F, 1'b0, 1'b0, 2'd2);
    expect_at(base + 3120, "tmo3",         1'b0, 5'h1F, 1'b0, 1'b0, 2'd3);
    expect_at(base + 4159, "tmo4_pre",     1'b1, 5'h1F, 1'b0, 1'b0, 2'd3);
    expect_at(base + 4160, "fault_set",    1'b0, 5'h1F, 1'b0, 1'b1, 2'd3);
    expect_at(base + 4300, "fault_hold",   1'b0, 5'h1F, 1'b0, 1'b1, 2'd3);
    expect_at(base + 4301, "restart_clr",  1'b0, 5'h1F, 1'b0, 1'b0, 2'd0);
    expect_at(base + 4316, "restart_idle", 1'b0, 5'h1F, 1'b0, 1'b0, 2'd0);
    expect_at(base + 4317, "restart_en",   1'b1, 5'h1F, 1'b0, 1'b0, 2'd0);
    at_cyc(base + 4300);
    restart = 1'b1;
    @(negedge clk_in);
    restart = 1'b0;

    // Restart lands on the same edge as the final timeout.
    r = base + 4301;
    expect_at(r + 4159, "tmo4b_pre",      1'b1, 5'h1F, 1'b0, 1'b0, 2'd3);
    expect_at(r + 4160, "restart_vs_tmo", 1'b0, 5'h1F, 1'b0, 1'b0, 2'd0);
    expect_at(r + 4175, "restart2_idle",  1'b0, 5'h1F, 1'b0, 1'b0, 2'd0);
    expect_at(r + 4176, "restart2_en",    1'b1, 5'h1F, 1'b0, 1'b0, 2'd0);
    at_cyc(r + 4159);
    restart = 1'b1;
    @(negedge clk_in);
    restart = 1'b0;
    at_cyc(r + 4180);

    @(negedge clk_in);
    if (sb.size() > 0) begin
      total += sb.size();
      bad   += sb.size();
      $display("FAIL drain: %0d expectations never sampled", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
